// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer driving one shared multi-cycle adder.
// Every request runs exactly two adder operations: an arithmetic step
// (a+b or a-b), then a correction step against M (S-M or S+M). The
// result is picked from the two outcomes, so latency never depends on
// the operand values.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, mode_sub    request (sampled only in IDLE), 0 = add, 1 = sub
//   in_a, in_b, in_m   operands (a < M, b < M) and modulus (M < 2^(OPW-1))
//   busy, done         busy from accept through the done cycle; done pulse
//   result, error      modular result (< M); timeout flag
//   add_start, add_subtract, add_in_a, add_in_b    adder request side
//   add_result, add_done                           adder response side
//
// Optional watchdog: define MODADDSUB_TIMEOUT_EN to abort a WAIT state
// after TIMEOUT cycles without add_done (error=1, result=0). Without it
// the WAIT states block indefinitely and error stays 0.
module mod_addsub_ctrl #(
  parameter int unsigned OPW     = 514,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           mode_sub,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  input  logic [OPW-1:0] in_m,
  output logic           busy,
  output logic           done,
  output logic [OPW-1:0] result,
  output logic           error,
  output logic           add_start,
  output logic           add_subtract,
  output logic [OPW-1:0] add_in_a,
  output logic [OPW-1:0] add_in_b,
  input  logic [OPW:0]   add_result,
  input  logic           add_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    WAIT1  = 3'd2,
    ISSUE2 = 3'd3,
    WAIT2  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic           busy_nxt, done_nxt, error_nxt;
  logic [OPW-1:0] result_nxt;
  logic           add_start_nxt, add_subtract_nxt;
  logic [OPW-1:0] add_in_a_nxt, add_in_b_nxt;
  logic [OPW-1:0] m_q, m_nxt;
  logic           sub_q, sub_nxt;
  logic [OPW:0]   s_q, s_nxt;

`ifdef MODADDSUB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          expired_c;

  // Fires on the TIMEOUT-th WAIT cycle without add_done.
  assign expired_c = (cnt == CW'(TIMEOUT - 1));
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      result       <= '0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
      m_q          <= '0;
      sub_q        <= 1'b0;
      s_q          <= '0;
`ifdef MODADDSUB_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      state        <= state_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      error        <= error_nxt;
      result       <= result_nxt;
      add_start    <= add_start_nxt;
      add_subtract <= add_subtract_nxt;
      add_in_a     <= add_in_a_nxt;
      add_in_b     <= add_in_b_nxt;
      m_q          <= m_nxt;
      sub_q        <= sub_nxt;
      s_q          <= s_nxt;
`ifdef MODADDSUB_TIMEOUT_EN
      cnt          <= cnt_nxt;
`endif
    end
  end

  // Next state and next values of all registers. Outputs are set on the
  // edge entering a state, so e.g. add_start is high during ISSUE1/ISSUE2.
  always_comb begin
    state_nxt        = state;
    busy_nxt         = busy;
    done_nxt         = 1'b0;
    error_nxt        = error;
    result_nxt       = result;
    add_start_nxt    = 1'b0;
    add_subtract_nxt = add_subtract;
    add_in_a_nxt     = add_in_a;
    add_in_b_nxt     = add_in_b;
    m_nxt            = m_q;
    sub_nxt          = sub_q;
    s_nxt            = s_q;
`ifdef MODADDSUB_TIMEOUT_EN
    cnt_nxt          = cnt;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt        = ISSUE1;
          busy_nxt         = 1'b1;
          error_nxt        = 1'b0;
          m_nxt            = in_m;
          sub_nxt          = mode_sub;
          add_start_nxt    = 1'b1;
          add_subtract_nxt = mode_sub;
          add_in_a_nxt     = in_a;
          add_in_b_nxt     = in_b;
        end
      end

      // add_done may be stale from the previous operation here, so it is
      // not looked at until WAIT1.
      ISSUE1: begin
        state_nxt = WAIT1;
`ifdef MODADDSUB_TIMEOUT_EN
        cnt_nxt   = '0;
`endif
      end

      // Capture S and issue the correction: S-M for add, S+M for sub.
      WAIT1: begin
        if (add_done) begin
          state_nxt        = ISSUE2;
          s_nxt            = add_result;
          add_start_nxt    = 1'b1;
          add_subtract_nxt = ~sub_q;
          add_in_a_nxt     = add_result[OPW-1:0];
          add_in_b_nxt     = m_q;
        end
`ifdef MODADDSUB_TIMEOUT_EN
        else if (expired_c) begin
          state_nxt  = FIN;
          done_nxt   = 1'b1;
          error_nxt  = 1'b1;
          result_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end

      ISSUE2: begin
        state_nxt = WAIT2;
`ifdef MODADDSUB_TIMEOUT_EN
        cnt_nxt   = '0;
`endif
      end

      // D = add_result. Add: keep D unless it went negative.
      // Sub: keep S unless a<b, in which case D = S+M is the answer.
      WAIT2: begin
        if (add_done) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
          if (!sub_q) begin
            result_nxt = add_result[OPW] ? s_q[OPW-1:0] : add_result[OPW-1:0];
          end else begin
            result_nxt = s_q[OPW] ? add_result[OPW-1:0] : s_q[OPW-1:0];
          end
        end
`ifdef MODADDSUB_TIMEOUT_EN
        else if (expired_c) begin
          state_nxt  = FIN;
          done_nxt   = 1'b1;
          error_nxt  = 1'b1;
          result_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end

      // done is high in this cycle; busy drops on leaving.
      FIN: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mod_addsub_ctrl.md
Name: mod_addsub_ctrl

Overview:
- Initiator/sequencer for the multi-cycle 514-bit adder/subtractor (start/done responder).
- Performs a full modular addition or modular subtraction by issuing exactly two adder operations:
  - an arithmetic step;
  - a correction step against modulus M.
- Selects the correct result without a data-dependent change in latency.
- Sits between the Montgomery/exponentiation control and one shared adder instance.

Parameters:
- OPW, 514, operand width; must equal adder input width (adder result is OPW+1).
- TIMEOUT, 32, max cycles to wait for add_done per operation (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode_sub  in  1  0 = (a+b) mod M, 1 = (a-b) mod M
- in_a  in  OPW  operand a, required a < M
- in_b  in  OPW  operand b, required b < M
- in_m  in  OPW  modulus M, required M < 2^(OPW-1)
- busy  out  1  high from accepted start until the done cycle inclusive
- done  out  1  one-cycle pulse; result valid and held until next accepted start
- result  out  OPW  modular result, < M
- error  out  1  timeout flag (optional feature only; else constant 0)
- add_start  out  1  one-cycle start to adder
- add_subtract  out  1  adder mode; held stable from add_start until add_done seen
- add_in_a  out  OPW  adder operand a
- add_in_b  out  OPW  adder operand b
- add_result  in  OPW+1  adder output; bit OPW = carry/sign
- add_done  in  1  adder level-done; stays high until next add_start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - state IDLE;
  - busy, done, error, add_start, add_subtract all 0;
  - result 0;
  - add_in_a and add_in_b 0;
  - operand latches 0.
- Accepting a request:
  - IDLE + start: latch in_a, in_b, in_m, mode_sub; set busy; go to ISSUE1.
  - start while not in IDLE is ignored (no queue).
- States: IDLE -> ISSUE1 -> WAIT1 -> ISSUE2 -> WAIT2 -> FIN -> IDLE.
- ISSUE1:
  - add_start=1 for exactly one cycle; add_in_a=a; add_in_b=b; add_subtract=mode_sub.
  - add_done is ignored in this cycle, because it may still be high from a previous operation.
- WAIT1:
  - On add_done=1, capture S = add_result and go to ISSUE2.
- ISSUE2 when mode_sub=0 (addition):
  - Issue S[OPW-1:0] - M with add_subtract=1.
  - S < 2M < 2^OPW, so no truncation loss.
- ISSUE2 when mode_sub=1 (subtraction):
  - Issue S[OPW-1:0] + M with add_subtract=0.
  - S is the two's-complement a-b.
- WAIT2:
  - On add_done=1, capture D = add_result and go to FIN.
- FIN, result selection:
  - Addition: result = D[OPW-1:0] if D[OPW]=0 (non-negative), else S[OPW-1:0].
  - Subtraction: result = S[OPW-1:0] if S[OPW]=0 (a>=b), else D[OPW-1:0].
  - Pulse done=1 for one cycle, clear busy, return to IDLE.
- Constant time:
  - Both adder operations are always executed.
  - Total latency = 2 x adder latency + 4 cycles (ISSUE1, ISSUE2, FIN, plus the accept edge), independent of operand values.
- Signal holding rules:
  - add_in_a, add_in_b and add_subtract are held stable through each WAIT state, because the adder samples the mode every cycle.
  - add_start is 0 in all states except ISSUE1 and ISSUE2.
- Reset mid-operation:
  - Immediately return to IDLE with all outputs at reset values.
  - The adder is not reset by this block; its stale add_done is ignored by the ISSUE-state masking.
- Boundaries:
  - a+b = M gives D = 0, non-negative, so result 0.
  - a = b in subtraction gives S = 0, so result 0.
  - a = b = 0 gives result 0.

Optional Feature:
- Macro: MODADDSUB_TIMEOUT_EN.
- Defined:
  - A per-operation counter runs in WAIT1/WAIT2 and clears on entering each WAIT.
  - If add_done has not arrived after TIMEOUT cycles, go to FIN with error=1, done=1 and result=0.
  - error stays set until the next accepted start.
- Not defined:
  - No counter; WAIT states block indefinitely.
  - error is tied to 0.

Test Plan:
- M=13, a=7, b=9, mode_sub=0 -> result=3; exactly 2 add_start pulses; latency equals that of the next case.
- M=13, a=5, b=4, mode_sub=0 -> result=9 (no correction taken); same latency as the previous case.
- M=13, a=3, b=8, mode_sub=1 -> result=8. Separately, a=8, b=3 -> result=5. Separately, a=b=6 -> result=0.
- M=13, a=6, b=7, mode_sub=0 -> result=0. Then random 512-bit M, a and b (1000 vectors) checked against a reference model.
- start pulsed again during WAIT1 -> ignored; done pulses once; add_start pulses exactly twice. Reset asserted in WAIT2 -> next cycle busy=0, done=0, and a fresh request completes correctly.
- With MODADDSUB_TIMEOUT_EN and TIMEOUT=32, stub adder never raises add_done -> error=1 and done=1 at cycle 32 of WAIT1; result=0.
